// File: rtl/rf_refill_writer.sv
// ---------------------------------------------------------------------------
// rf_refill_writer
//
// Fills a small register file from memory one cache-line-sized block at a
// time, and can also clear the whole register file to zero.
//
//   IDLE   : waits for work. A flush request wins over a refill request.
//   FLUSH  : writes zero to every word, address 0 .. NUM_WORDS-1, one word
//            per cycle. flush_ack_o pulses in the cycle after the last write.
//   REFILL : issues BEATS memory beat requests for the latched line, and
//            writes each response into the register file as it arrives.
//            refill_done_o pulses in the cycle after the last beat is written.
//
// Handshakes (valid/ready): a transfer on refill_req_i/refill_gnt_o or on
// mem_req_o/mem_gnt_i happens on a rising edge where both are high. The
// requester holds its request and payload stable until that edge. Memory
// responses (mem_rvalid_i) have no back-pressure and come back in order,
// one per granted request.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush_req_i         level request to zero the register file
//   flush_ack_o         one-cycle pulse, flush complete
//   refill_req_i        refill request (valid)
//   refill_gnt_o        refill request accepted (ready)
//   refill_addr_i       byte address anywhere inside the line to fetch
//   refill_idx_i        destination line index in the register file
//   refill_done_o       one-cycle pulse, last beat of the line written
//   mem_req_o/addr_o    memory beat request and its byte address
//   mem_gnt_i           memory accepted the beat request
//   mem_rvalid_i/rdata  in-order response data
//   wr_en_o/addr_o/data register-file write port (writes on the same edge)
//   busy_o              high whenever the FSM is not in IDLE
//   fsm_state_o         current FSM state (debug): 0 IDLE, 1 FLUSH, 2 REFILL
// ---------------------------------------------------------------------------
module rf_refill_writer #(
  parameter int ADDR_WIDTH       = 5,
  parameter int DATA_WIDTH       = 32,
  parameter int BEATS_LOG2       = 2,
  parameter int FETCH_ADDR_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush_req_i,
  output logic                             flush_ack_o,
  input  logic                             refill_req_i,
  output logic                             refill_gnt_o,
  input  logic [FETCH_ADDR_WIDTH-1:0]      refill_addr_i,
  input  logic [ADDR_WIDTH-BEATS_LOG2-1:0] refill_idx_i,
  output logic                             refill_done_o,
  output logic                             mem_req_o,
  output logic [FETCH_ADDR_WIDTH-1:0]      mem_addr_o,
  input  logic                             mem_gnt_i,
  input  logic                             mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i,
  output logic                             wr_en_o,
  output logic [ADDR_WIDTH-1:0]            wr_addr_o,
  output logic [DATA_WIDTH-1:0]            wr_data_o,
  output logic                             busy_o,
  output logic [1:0]                       fsm_state_o
);

  localparam int BEATS      = 1 << BEATS_LOG2;
  localparam int BYTES_LOG2 = $clog2(DATA_WIDTH / 8);
  localparam int LINE_LOG2  = BYTES_LOG2 + BEATS_LOG2;
  localparam int CNT_W      = BEATS_LOG2 + 1;
  localparam int IDX_W      = ADDR_WIDTH - BEATS_LOG2;

  // One extra counter bit so "all BEATS issued" is distinguishable from 0.
  localparam logic [CNT_W-1:0]            BEATS_CNT  = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0]            LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0]       FLUSH_LAST = '1;
  // Clears the byte-in-beat and beat-in-line bits of the refill address.
  localparam logic [FETCH_ADDR_WIDTH-1:0] LINE_MASK  = {FETCH_ADDR_WIDTH{1'b1}} << LINE_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_REFILL = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       flush_cnt_q;
  logic [CNT_W-1:0]            req_cnt_q;
  logic [CNT_W-1:0]            rsp_cnt_q;
  logic [FETCH_ADDR_WIDTH-1:0] base_q;
  logic [IDX_W-1:0]            idx_q;
  logic                        done_q;
  logic                        ack_q;

  logic                        refill_accept;
  logic                        req_fire;
  logic                        rsp_fire;
  logic                        rsp_last;
  logic                        flush_last;
  logic [FETCH_ADDR_WIDTH-1:0] beat_off;
  logic                        spurious_rsp;

  assign beat_off      = FETCH_ADDR_WIDTH'(req_cnt_q) << BYTES_LOG2;
  assign refill_accept = refill_gnt_o;
  assign rsp_last      = (rsp_cnt_q == LAST_BEAT);
  assign flush_last    = (flush_cnt_q == FLUSH_LAST);

  // A response that does not match an outstanding request is dropped.
  assign spurious_rsp  = mem_rvalid_i & ~rsp_fire;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_req_i) begin
          state_d = ST_FLUSH;
        end else if (refill_accept) begin
          state_d = ST_REFILL;
        end
      end
      ST_FLUSH: begin
        if (flush_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_REFILL: begin
        // A pending flush is left alone until the line is complete.
        if (rsp_fire && rsp_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    refill_gnt_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    wr_en_o      = 1'b0;
    wr_addr_o    = '0;
    wr_data_o    = '0;
    req_fire     = 1'b0;
    rsp_fire     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // rst_n gates the grant so every output is low while in reset.
        refill_gnt_o = rst_n & refill_req_i & ~flush_req_i;
      end
      ST_FLUSH: begin
        wr_en_o   = 1'b1;
        wr_addr_o = flush_cnt_q;
      end
      ST_REFILL: begin
        // The address only depends on req_cnt_q, so it holds while stalled.
        if (req_cnt_q < BEATS_CNT) begin
          mem_req_o  = 1'b1;
          mem_addr_o = base_q + beat_off;
        end
        req_fire = mem_req_o & mem_gnt_i;
        if (mem_rvalid_i && (rsp_cnt_q != req_cnt_q)) begin
          rsp_fire  = 1'b1;
          wr_en_o   = 1'b1;
          wr_addr_o = {idx_q, rsp_cnt_q[BEATS_LOG2-1:0]};
          wr_data_o = mem_rdata_i;
        end
      end
      default: ;
    endcase
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign flush_ack_o   = ack_q;
  assign refill_done_o = done_q;
  assign fsm_state_o   = state_q;

  // -------------------------------------------------------------------------
  // Datapath: counters, latched request, completion pulses
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q <= '0;
      req_cnt_q   <= '0;
      rsp_cnt_q   <= '0;
      base_q      <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      done_q <= rsp_fire & rsp_last;
      ack_q  <= (state_q == ST_FLUSH) & flush_last;

      if (state_q == ST_FLUSH) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end else begin
        flush_cnt_q <= '0;
      end

      if (state_q == ST_IDLE) begin
        if (refill_accept) begin
          base_q    <= refill_addr_i & LINE_MASK;
          idx_q     <= refill_idx_i;
          req_cnt_q <= '0;
          rsp_cnt_q <= '0;
        end
      end else if (state_q == ST_REFILL) begin
        // Grant and response in the same cycle each advance their counter.
        if (req_fire) begin
          req_cnt_q <= req_cnt_q + 1'b1;
        end
        if (rsp_fire) begin
          rsp_cnt_q <= rsp_cnt_q + 1'b1;
        end
      end
    end
  end

  // Response with nothing outstanding: dropped, but reported in simulation.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!spurious_rsp)
        else $warning("rf_refill_writer: response without outstanding request ignored");
    end
  end

endmodule

// File: doc/rf_refill_writer.md
RF_REFILL_WRITER -- requirements
Module: rf_refill_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, meaning register-file word address width (NUM_WORDS = 2**ADDR_WIDTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word width and beat width.
REQ-003 SHALL have parameter BEATS_LOG2, default 2, meaning log2 of beats per line (BEATS = 2**BEATS_LOG2, BEATS_LOG2 < ADDR_WIDTH).
REQ-004 SHALL have parameter FETCH_ADDR_WIDTH, default 32, meaning memory byte-address width.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 flush_req_i  in  1  level request to zero the whole register file.
REQ-008 flush_ack_o  out  1  one-cycle pulse, flush complete.
REQ-009 refill_req_i  in  1  refill request, valid/ready with refill_gnt_o.
REQ-010 refill_gnt_o  out  1  refill request accepted.
REQ-011 refill_addr_i  in  FETCH_ADDR_WIDTH  byte address inside the line to fetch.
REQ-012 refill_idx_i  in  ADDR_WIDTH-BEATS_LOG2  destination line index.
REQ-013 refill_done_o  out  1  one-cycle pulse, last beat written.
REQ-014 mem_req_o  out  1  memory beat request; mem_addr_o  out  FETCH_ADDR_WIDTH  beat byte address; mem_gnt_i  in  1  request accepted.
REQ-015 mem_rvalid_i  in  1  response valid; mem_rdata_i  in  DATA_WIDTH  response data (in-order, one per granted request).
REQ-016 wr_en_o  out  1; wr_addr_o  out  ADDR_WIDTH; wr_data_o  out  DATA_WIDTH -- register-file write port, write on the same edge.
REQ-017 busy_o  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, FLUSH, REFILL.
REQ-019 IDLE: flush_req_i high -> FLUSH (flush has priority); else refill_gnt_o = refill_req_i, and on accept latch base = refill_addr_i with low log2(DATA_WIDTH/8)+BEATS_LOG2 bits zeroed, latch refill_idx_i, clear counters, -> REFILL.
REQ-020 refill_gnt_o SHALL be 0 outside IDLE and in IDLE while flush_req_i is high.
REQ-021 FLUSH: each cycle wr_en_o=1, wr_data_o=0, wr_addr_o=flush counter starting at 0; after address NUM_WORDS-1 is written, flush_ack_o pulses in the next cycle and FSM -> IDLE (NUM_WORDS writes, ack at cycle NUM_WORDS+1 after entry).
REQ-022 REFILL request side: mem_req_o high while req_cnt < BEATS; mem_addr_o = base + req_cnt*(DATA_WIDTH/8); req_cnt increments on mem_req_o & mem_gnt_i; mem_addr_o SHALL stay stable while mem_req_o high without grant.
REQ-023 REFILL response side: on mem_rvalid_i, wr_en_o=1, wr_addr_o={line idx, rsp_cnt}, wr_data_o=mem_rdata_i combinationally in the same cycle; rsp_cnt increments.
REQ-024 Multiple outstanding requests SHALL be allowed (up to BEATS); grant and rvalid in the same cycle SHALL both be processed.
REQ-025 When the BEATS-th response is written, refill_done_o SHALL pulse in the following cycle and FSM -> IDLE; new refill may be granted in that same cycle.
REQ-026 flush_req_i asserted during REFILL SHALL be held off until refill completes, then serviced from IDLE.
REQ-027 mem_rvalid_i with no outstanding request (rsp_cnt == req_cnt) SHALL be ignored (no write); simulation assertion SHALL flag it.
REQ-028 Counters SHALL be BEATS_LOG2+1 bits wide (no wrap inside a line); flush counter ADDR_WIDTH bits, terminal at all-ones.
REQ-029 wr_en_o SHALL never be asserted in IDLE.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, zero all counters and latches, and drive all outputs 0, including mid-FLUSH or mid-REFILL; no done/ack pulse after reset.

Verification
REQ-031 Reset then flush_req_i=1 one cycle (ADDR_WIDTH=5) -> 32 consecutive writes addr 0..31 data 0, flush_ack_o pulse next cycle, busy_o falls.
REQ-032 Refill addr 0x0000_1234, idx 3, gnt always 1, rvalid one cycle after gnt -> mem_addr_o 0x1230,0x1234,0x1238,0x123C; writes addr 12..15 with returned data; one refill_done_o.
REQ-033 Refill with mem_gnt_i stalled 3 cycles on beat 1 -> mem_addr_o held at base+4, no duplicate request, all 4 beats written in order.
REQ-034 flush_req_i raised during REFILL -> refill completes with refill_done_o, then full flush, flush_ack_o; refill_req_i and flush_req_i together in IDLE -> flush first, refill_gnt_o=0.
REQ-035 rst_n pulsed low after 2 of 4 beats -> outputs 0 immediately, no done pulse, next refill starts at beat 0.
REQ-036 Spurious mem_rvalid_i in IDLE -> no wr_en_o, assertion fires.
